// File: rtl/cva6_pma_region_unit.sv
// Runtime-programmable PMA region table with a single-register lookup pipeline.
// The power-on contents come from parameters, so the reset map matches the static SoC map.
module cva6_pma_region_unit #(
  parameter int unsigned NrRegions = 8,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRegions-1:0][3:0]           RstAttr   = '0,
  parameter logic [2:0]                          DefaultAttr = 3'b000,
  localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_region_o,
  output logic [2:0]           rsp_attr_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stageState_e;

  typedef enum logic [1:0] {
    FieldBase   = 2'd0,
    FieldLength = 2'd1,
    FieldAttr   = 2'd2,
    FieldRsvd   = 2'd3
  } cfgField_e;

  localparam int unsigned LockBit = 3;

  // Region table
  logic [NrRegions-1:0][AddrWidth-1:0] baseQ;
  logic [NrRegions-1:0][AddrWidth-1:0] lengthQ;
  logic [NrRegions-1:0][3:0]           attrQ;

  // Configuration decode
  logic idxValid;
  logic targetLocked;
  logic cfgReject;
  logic cfgAccept;
  logic cfgErrQ;

  // Lookup
  logic [NrRegions-1:0] regionMatch;
  logic                 lookupHit;
  logic [IdxW-1:0]      lookupIdx;
  logic [2:0]           lookupAttr;

  // Output stage
  stageState_e     stateQ, stateD;
  logic            reqAccept;
  logic            hitQ;
  logic [IdxW-1:0] regionQ;
  logic [2:0]      attrOutQ;

  // ---------------------------------------------------------------------------
  // Per-region window match. The end address is formed one bit wider so a
  // window ending exactly at 2^AddrWidth neither wraps nor loses its top entry.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NrRegions; g++) begin : gen_match
    logic [AddrWidth:0] windowEnd;
    assign windowEnd      = {1'b0, baseQ[g]} + {1'b0, lengthQ[g]};
    assign regionMatch[g] = (lengthQ[g] != '0)
                         && (req_addr_i >= baseQ[g])
                         && ({1'b0, req_addr_i} < windowEnd);
  end

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    lookupHit  = 1'b0;
    lookupIdx  = '0;
    lookupAttr = DefaultAttr;
    for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
      if (regionMatch[i]) begin
        lookupHit  = 1'b1;
        lookupIdx  = IdxW'(i);
        lookupAttr = attrQ[i][2:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    idxValid     = 32'(cfg_idx_i) < NrRegions;
    targetLocked = 1'b0;
    for (int i = 0; i < int'(NrRegions); i++) begin
      if (cfg_idx_i == IdxW'(i)) begin
        targetLocked = attrQ[i][LockBit];
      end
    end
    cfgReject = (cfgField_e'(cfg_field_i) == FieldRsvd) || !idxValid || targetLocked;
    cfgAccept = cfg_we_i && !cfgReject;
  end

  // NOTE: the region table is a handful of flops, not a RAM macro, so it takes
  // an async reset to the parameterised power-on map like any other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baseQ   <= RstBase;
      lengthQ <= RstLength;
      attrQ   <= RstAttr;
    end else if (cfgAccept) begin
      for (int i = 0; i < int'(NrRegions); i++) begin
        if (cfg_idx_i == IdxW'(i)) begin
          unique case (cfgField_e'(cfg_field_i))
            FieldBase:   baseQ[i]   <= cfg_wdata_i;
            FieldLength: lengthQ[i] <= cfg_wdata_i;
            FieldAttr:   attrQ[i]   <= cfg_wdata_i[3:0];
            default:     ;
          endcase
        end
      end
    end
  end

  // One pulse per rejected strobe; consecutive rejects give consecutive pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfgErrQ <= 1'b0;
    end else begin
      cfgErrQ <= cfg_we_i && cfgReject;
    end
  end

  assign cfg_err_o = cfgErrQ;

  // ---------------------------------------------------------------------------
  // Single-entry output stage
  // ---------------------------------------------------------------------------
  assign req_ready_o = (stateQ == EMPTY) || rsp_ready_i;
  assign reqAccept   = req_valid_i && req_ready_o;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      EMPTY:   if (reqAccept) stateD = FULL;
      FULL:    if (rsp_ready_i && !reqAccept) stateD = EMPTY;
      default: stateD = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the table write and a same-cycle lookup stay ordered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ   <= EMPTY;
      hitQ     <= 1'b0;
      regionQ  <= '0;
      attrOutQ <= 3'b000;
    end else begin
      stateQ <= stateD;
      if (reqAccept) begin
        hitQ     <= lookupHit;
        regionQ  <= lookupIdx;
        attrOutQ <= lookupAttr;
      end
    end
  end

  assign rsp_valid_o  = (stateQ == FULL);
  assign rsp_hit_o    = hitQ;
  assign rsp_region_o = regionQ;
  assign rsp_attr_o   = attrOutQ;

endmodule

// File: tb/tb_cva6_pma_region_unit.sv
// Directed bench for cva6_pma_region_unit: reset map, priority, top window,
// lock and error pulses, backpressure, same-cycle config ordering and async reset.
module tb_cva6_pma_region_unit;

  localparam int unsigned NrRegions = 8;
  localparam int unsigned AddrWidth = 64;
  localparam logic [NrRegions-1:0][AddrWidth-1:0] TbRstBase   = {448'd0, 64'h0000_0000_8000_0000};
  localparam logic [NrRegions-1:0][AddrWidth-1:0] TbRstLength = {448'd0, 64'h0000_0000_0000_1000};
  localparam logic [NrRegions-1:0][3:0]           TbRstAttr   = {28'd0, 4'b0011};
  localparam logic [2:0]                          TbDefault   = 3'b110;

  logic        clk_i;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [2:0]  cfg_idx_i;
  logic [1:0]  cfg_field_i;
  logic [63:0] cfg_wdata_i;
  logic        cfg_err_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_hit_o;
  logic [2:0]  rsp_region_o;
  logic [2:0]  rsp_attr_o;

  int checks;
  int failures;

  cva6_pma_region_unit #(
    .NrRegions  (NrRegions),
    .AddrWidth  (AddrWidth),
    .RstBase    (TbRstBase),
    .RstLength  (TbRstLength),
    .RstAttr    (TbRstAttr),
    .DefaultAttr(TbDefault)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_we_i    (cfg_we_i),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_field_i (cfg_field_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_err_o   (cfg_err_o),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_hit_o   (rsp_hit_o),
    .rsp_region_o(rsp_region_o),
    .rsp_attr_o  (rsp_attr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // {valid, hit, region, attr}
  function automatic logic [7:0] pack_rsp(input logic v, input logic h,
                                          input logic [2:0] r, input logic [2:0] a);
    return {v, h, r, a};
  endfunction

  function automatic logic [7:0] observed();
    return {rsp_valid_o, rsp_hit_o, rsp_region_o, rsp_attr_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input logic [63:0] addr);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [1:0] field, input logic [63:0] data);
    cfg_we_i    = 1'b1;
    cfg_idx_i   = idx;
    cfg_field_i = field;
    cfg_wdata_i = data;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    exp = pack_rsp(1'b0, 1'b0, 3'd0, 3'b000);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL reset_rsp: got %b want %b", observed(), exp);
    end
    checks++;
    if (cfg_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctl: got err=%b ready=%b want err=0 ready=1", cfg_err_o, req_ready_o);
    end
  endtask

  task automatic test_reset_map();
    logic [7:0] exp;
    lookup(64'h0000_0000_8000_0FFF);
    exp = pack_rsp(1'b1, 1'b1, 3'd0, 3'b011);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL map_last_byte: got %b want %b", observed(), exp);
    end
    lookup(64'h0000_0000_8000_1000);
    exp = pack_rsp(1'b1, 1'b0, 3'd0, TbDefault);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL map_past_end: got %b want %b", observed(), exp);
    end
    lookup(64'h0000_0000_7FFF_FFFF);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL map_below_base: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] exp;
    cfg_write(3'd1, 2'd0, 64'h1000);
    cfg_write(3'd1, 2'd1, 64'h100);
    cfg_write(3'd1, 2'd2, 64'h4);
    cfg_write(3'd3, 2'd0, 64'h1000);
    cfg_write(3'd3, 2'd1, 64'h1000);
    cfg_write(3'd3, 2'd2, 64'h1);
    lookup(64'h1080);
    exp = pack_rsp(1'b1, 1'b1, 3'd1, 3'b100);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL overlap_low_wins: got %b want %b", observed(), exp);
    end
    lookup(64'h1180);
    exp = pack_rsp(1'b1, 1'b1, 3'd3, 3'b001);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL overlap_outer: got %b want %b", observed(), exp);
    end
    lookup(64'h2000);
    exp = pack_rsp(1'b1, 1'b0, 3'd0, TbDefault);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL overlap_end_excl: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_top_window();
    logic [7:0] exp;
    cfg_write(3'd4, 2'd0, 64'hFFFF_FFFF_FFFF_FFF0);
    cfg_write(3'd4, 2'd1, 64'h10);
    cfg_write(3'd4, 2'd2, 64'h2);
    lookup(64'hFFFF_FFFF_FFFF_FFFF);
    exp = pack_rsp(1'b1, 1'b1, 3'd4, 3'b010);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL top_last_addr: got %b want %b", observed(), exp);
    end
    lookup(64'hFFFF_FFFF_FFFF_FFF0);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL top_base: got %b want %b", observed(), exp);
    end
    lookup(64'h0);
    exp = pack_rsp(1'b1, 1'b0, 3'd0, TbDefault);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL top_no_wrap: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp;
    cfg_write(3'd2, 2'd0, 64'h5000);
    cfg_write(3'd2, 2'd1, 64'h100);
    cfg_write(3'd2, 2'd2, 64'h9);
    checks++;
    if (cfg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_set_err: got %b want 0", cfg_err_o);
    end
    cfg_write(3'd2, 2'd0, 64'h9000);
    checks++;
    if (cfg_err_o !== 1'b1) begin
      failures++;
      $display("FAIL lock_reject_pulse: got %b want 1", cfg_err_o);
    end
    tick();
    checks++;
    if (cfg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_pulse_width: got %b want 0", cfg_err_o);
    end
    lookup(64'h5010);
    exp = pack_rsp(1'b1, 1'b1, 3'd2, 3'b001);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL lock_base_kept: got %b want %b", observed(), exp);
    end
    // Two back-to-back reserved-field writes: two consecutive pulses, then idle.
    cfg_we_i    = 1'b1;
    cfg_idx_i   = 3'd5;
    cfg_field_i = 2'd3;
    cfg_wdata_i = 64'h1;
    tick();
    checks++;
    if (cfg_err_o !== 1'b1) begin
      failures++;
      $display("FAIL rsvd_pulse1: got %b want 1", cfg_err_o);
    end
    tick();
    cfg_we_i = 1'b0;
    checks++;
    if (cfg_err_o !== 1'b1) begin
      failures++;
      $display("FAIL rsvd_pulse2: got %b want 1", cfg_err_o);
    end
    tick();
    checks++;
    if (cfg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_idle: got %b want 0", cfg_err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [4];
    logic [7:0]  exps  [4];
    addrs[0] = 64'h8000_0000; exps[0] = pack_rsp(1'b1, 1'b1, 3'd0, 3'b011);
    addrs[1] = 64'h1080;      exps[1] = pack_rsp(1'b1, 1'b1, 3'd1, 3'b100);
    addrs[2] = 64'h1180;      exps[2] = pack_rsp(1'b1, 1'b1, 3'd3, 3'b001);
    addrs[3] = 64'h2000;      exps[3] = pack_rsp(1'b1, 1'b0, 3'd0, TbDefault);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = addrs[0];
    tick();
    req_addr_i = addrs[1];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req_ready_o !== 1'b0 || observed() !== exps[0]) begin
        failures++;
        $display("FAIL stall_cycle%0d: got ready=%b rsp=%b want ready=0 rsp=%b",
                 c, req_ready_o, observed(), exps[0]);
      end
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: got %b want 1", req_ready_o);
    end
    for (int k = 1; k < 4; k++) begin
      req_addr_i = addrs[k];
      tick();
      checks++;
      if (observed() !== exps[k]) begin
        failures++;
        $display("FAIL stream_rsp%0d: got %b want %b", k, observed(), exps[k]);
      end
    end
    req_valid_i = 1'b0;
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain: got %b want 0", rsp_valid_o);
    end
  endtask

  task automatic test_same_cycle_cfg();
    logic [7:0] exp;
    cfg_we_i    = 1'b1;
    cfg_idx_i   = 3'd0;
    cfg_field_i = 2'd1;
    cfg_wdata_i = 64'h0;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_0010;
    tick();
    cfg_we_i    = 1'b0;
    req_valid_i = 1'b0;
    exp = pack_rsp(1'b1, 1'b1, 3'd0, 3'b011);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL same_cycle_old: got %b want %b", observed(), exp);
    end
    lookup(64'h8000_0010);
    exp = pack_rsp(1'b1, 1'b0, 3'd0, TbDefault);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL next_lookup_new: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    rsp_ready_i = 1'b0;
    lookup(64'h1080);
    rst_ni = 1'b0;
    #1;
    exp = pack_rsp(1'b0, 1'b0, 3'd0, 3'b000);
    checks++;
    if (observed() !== exp || cfg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got rsp=%b err=%b want rsp=%b err=0", observed(), cfg_err_o, exp);
    end
    rsp_ready_i = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    lookup(64'h8000_0010);
    exp = pack_rsp(1'b1, 1'b1, 3'd0, 3'b011);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL reset_restores_map: got %b want %b", observed(), exp);
    end
    lookup(64'h1080);
    exp = pack_rsp(1'b1, 1'b0, 3'd0, TbDefault);
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL reset_clears_region1: got %b want %b", observed(), exp);
    end
    cfg_write(3'd2, 2'd0, 64'h7000);
    checks++;
    if (cfg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears_lock: got %b want 0", cfg_err_o);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_ni      = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_idx_i   = '0;
    cfg_field_i = '0;
    cfg_wdata_i = '0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    test_reset_map();
    test_overlap();
    test_top_window();
    test_lock();
    test_back_to_back();
    test_same_cycle_cfg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
